// File: rtl/mod_exp_ctrl_pkg.sv
// mod_exp_ctrl_pkg: shared state encoding and default widths for the modular exponentiation controller
package mod_exp_ctrl_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_EXP_WIDTH = 32;
   typedef enum logic [2:0] {IDLE, PRE, SCAN, SQR, MUL, POST, DONE} state_t;
endpackage

// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: request/response and Montgomery multiplier signals of the exponentiation controller
interface mod_exp_ctrl_if
   import mod_exp_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int EXP_WIDTH = DEF_EXP_WIDTH
);
   logic start;
   logic [WIDTH-1:0] base;
   logic [EXP_WIDTH-1:0] exp;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] r2;
   logic busy;
   logic done;
   logic err;
   logic [WIDTH-1:0] result;
   logic mm_start;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_n;
   logic [WIDTH-1:0] mm_y;
   logic mm_done;
   modport master (
      output start, base, exp, n, r2, mm_y, mm_done,
      input busy, done, err, result, mm_start, mm_a, mm_b, mm_n
   );
   modport slave (
      input start, base, exp, n, r2, mm_y, mm_done,
      output busy, done, err, result, mm_start, mm_a, mm_b, mm_n
   );
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer driving an external Montgomery multiplier
module mod_exp_ctrl
   import mod_exp_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
   input logic clk,
   input logic rst,
   mod_exp_ctrl_if.slave bus
);
   localparam int IW = $clog2(EXP_WIDTH);
   state_t state, state_d;
   logic wait_q, wait_d;
   logic [IW-1:0] idx;
   logic [WIDTH-1:0] base_q, n_q, r2_q, bm, acc, result_q;
   logic [EXP_WIDTH-1:0] exp_q;
   logic err_q, n_bad, exp_zero, op, cap, last, bit_q;
   assign n_bad = ~n_q[0] | (n_q == WIDTH'(1));
   assign exp_zero = exp_q == '0;
   assign op = state inside {PRE, SQR, MUL, POST};
   assign cap = op & wait_q & bus.mm_done;
   assign last = idx == '0;
   assign bit_q = exp_q[idx];
   // wait_q marks the post-launch cycles, so a same-cycle mm_done is never taken as a result
   assign wait_d = op & (bus.mm_start | (wait_q & ~bus.mm_done));
   assign bus.mm_start = op & ~wait_q & ~(state == PRE & (n_bad | exp_zero));
   assign bus.mm_a = state == PRE ? base_q : (state inside {SQR, MUL, POST}) ? acc : '0;
   assign bus.mm_b = state == PRE ? r2_q : state == SQR ? acc : state == MUL ? bm :
                     state == POST ? WIDTH'(1) : '0;
   assign bus.mm_n = n_q;
   assign bus.busy = state != IDLE & state != DONE;
   assign bus.done = state == DONE;
   assign bus.err = err_q;
   assign bus.result = result_q;
   always_comb begin
      state_d = state;
      case (state)
         IDLE: state_d = bus.start ? PRE : IDLE;
         PRE: state_d = (n_bad | exp_zero) ? DONE : cap ? SCAN : PRE;
         SCAN: state_d = ~bit_q ? SCAN : last ? POST : SQR;
         SQR: state_d = ~cap ? SQR : bit_q ? MUL : last ? POST : SQR;
         MUL: state_d = ~cap ? MUL : last ? POST : SQR;
         POST: state_d = cap ? DONE : POST;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wait_q <= 1'b0;
         idx <= '0;
         base_q <= '0;
         exp_q <= '0;
         n_q <= '0;
         r2_q <= '0;
         bm <= '0;
         acc <= '0;
         result_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         wait_q <= wait_d;
         if (state == IDLE & bus.start) begin
            base_q <= bus.base;
            exp_q <= bus.exp;
            n_q <= bus.n;
            r2_q <= bus.r2;
            idx <= IW'(EXP_WIDTH - 1);
            result_q <= '0;
            err_q <= 1'b0;
         end
         if (state == PRE & n_bad) err_q <= 1'b1;
         if (state == PRE & ~n_bad & exp_zero) result_q <= WIDTH'(1);
         if (state == PRE & cap) bm <= bus.mm_y;
         if (state == SCAN & bit_q) acc <= bm;
         if ((state == SQR | state == MUL) & cap) acc <= bus.mm_y;
         if (state == POST & cap) result_q <= bus.mm_y;
         // a set bit in SQR keeps idx for the following MUL; idx never wraps below 0
         if (~last & (state == SCAN | (state == SQR & cap & ~bit_q) | (state == MUL & cap)))
            idx <= idx - 1'b1;
      end
   end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: table-driven check of mod_exp_ctrl against a behavioural Montgomery multiplier
module tb_mod_exp_ctrl;
   localparam int W = 32;
   localparam int EW = 32;
   typedef struct {
      logic [W-1:0] base;
      logic [EW-1:0] exp;
      logic [W-1:0] n;
      logic [W-1:0] r2;
      logic [W-1:0] res;
      logic err;
      int pulses;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   vec_t vecs[9];
   always #5 clk = ~clk;
   mod_exp_ctrl_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus();
   mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut(.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask
   function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] n);
      longint unsigned nn, rm, rinv, p;
      nn = 64'(n);
      if (nn < 2) return '0;
      rm = 64'h1_0000_0000 % nn;
      rinv = 0;
      for (longint unsigned i = 1; i < nn && i < 4096; i++)
         if ((i * rm) % nn == 1) rinv = i;
      p = ((64'(a) % nn) * (64'(b) % nn)) % nn;
      return W'((p * rinv) % nn);
   endfunction
   // behavioural MM: random 1..40 cycle latency, cleared by the shared reset
   initial begin
      logic [W-1:0] ma, mb, mn;
      int cnt;
      bit pend;
      pend = 0;
      cnt = 0;
      bus.mm_done = 1'b0;
      bus.mm_y = '0;
      forever begin
         @(negedge clk);
         bus.mm_done = 1'b0;
         if (rst) pend = 0;
         else begin
            if (pend) begin
               if (cnt == 0) begin
                  bus.mm_y = mont(ma, mb, mn);
                  bus.mm_done = 1'b1;
                  pend = 0;
               end else cnt--;
            end
            if (bus.mm_start) begin
               ma = bus.mm_a;
               mb = bus.mm_b;
               mn = bus.mm_n;
               pend = 1;
               cnt = $urandom_range(40, 1) - 1;
            end
         end
      end
   end
   task automatic run(input vec_t v, input bit spam, input string tag);
      int np, cyc, nd;
      bit seen;
      np = 0;
      cyc = 0;
      seen = 0;
      bus.base = v.base;
      bus.exp = v.exp;
      bus.n = v.n;
      bus.r2 = v.r2;
      bus.start = 1'b1;
      while (!seen && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         bus.start = spam;
         if (spam) begin
            bus.base = W'(cyc * 7);
            bus.exp = EW'(cyc);
            bus.n = W'(cyc * 2 + 31);
            bus.r2 = W'(cyc);
         end
         if (bus.mm_start) np++;
         if (bus.done) begin
            seen = 1;
            chk({tag, " result"}, 64'(bus.result), 64'(v.res));
            chk({tag, " err"}, 64'(bus.err), 64'(v.err));
            chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
            chk({tag, " mm_start count"}, 64'(np), 64'(v.pulses));
            if (v.pulses == 0) chk({tag, " done latency"}, 64'(cyc), 64'd2);
         end else if (cyc == 1) chk({tag, " busy after accept"}, 64'(bus.busy), 64'd1);
      end
      chk({tag, " done seen"}, 64'(seen), 64'd1);
      @(negedge clk);
      bus.start = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done) nd++;
         @(negedge clk);
      end
      chk({tag, " extra done"}, 64'(nd), 64'd0);
      chk({tag, " result held"}, 64'(bus.result), 64'(v.res));
      chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
   endtask
   task automatic check_zero(input string tag);
      chk({tag, " busy"}, 64'(bus.busy), 64'd0);
      chk({tag, " done"}, 64'(bus.done), 64'd0);
      chk({tag, " err"}, 64'(bus.err), 64'd0);
      chk({tag, " result"}, 64'(bus.result), 64'd0);
      chk({tag, " mm_start"}, 64'(bus.mm_start), 64'd0);
      chk({tag, " mm_a"}, 64'(bus.mm_a), 64'd0);
      chk({tag, " mm_b"}, 64'(bus.mm_b), 64'd0);
      chk({tag, " mm_n"}, 64'(bus.mm_n), 64'd0);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      int np, cyc, nd;
      vecs[0] = '{32'd23, 32'd31, 32'd29, 32'd24, 32'd16, 1'b0, 10};
      vecs[1] = '{32'd2, 32'd5, 32'd29, 32'd24, 32'd3, 1'b0, 5};
      vecs[2] = '{32'd23, 32'd1, 32'd29, 32'd24, 32'd23, 1'b0, 2};
      vecs[3] = '{32'd5, 32'd0, 32'd29, 32'd24, 32'd1, 1'b0, 0};
      vecs[4] = '{32'd5, 32'd7, 32'd28, 32'd0, 32'd0, 1'b1, 0};
      vecs[5] = '{32'd0, 32'd3, 32'd1, 32'd0, 32'd0, 1'b1, 0};
      vecs[6] = '{32'd7, 32'h8000_0000, 32'd29, 32'd24, 32'd20, 1'b0, 33};
      vecs[7] = '{32'd0, 32'd2, 32'd29, 32'd24, 32'd0, 1'b0, 3};
      vecs[8] = '{32'd9, 32'd0, 32'd28, 32'd0, 32'd0, 1'b1, 0};
      rst = 1'b1;
      bus.start = 1'b0;
      bus.base = '0;
      bus.exp = '0;
      bus.n = '0;
      bus.r2 = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));
      // reset during the fourth multiplier wait of the first vector
      bus.base = vecs[0].base;
      bus.exp = vecs[0].exp;
      bus.n = vecs[0].n;
      bus.r2 = vecs[0].r2;
      bus.start = 1'b1;
      np = 0;
      cyc = 0;
      while (np < 4 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (bus.mm_start) np++;
      end
      chk("abort reached 4th op", 64'(np), 64'd4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("abort");
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      chk("abort no done", 64'(nd), 64'd0);
      run(vecs[0], 1'b0, "rerun");
      run(vecs[0], 1'b1, "spam");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
